// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches one imem word per cycle into a
// 2-entry queue and hands instructions to decode over valid/ready.
module imem_fetch_ctrl #(
  parameter int                     ADDR_WIDTH  = 5,
  parameter int                     INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   halted
);

  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  q_pc    [2];
  logic [INSTR_WIDTH-1:0] q_instr [2];
  logic [1:0]             count;
  logic                   halt_q;

  logic       deq;
  logic       fetch;
  logic       is_halt;
  logic [1:0] fill;
  logic       wr_idx;

  assign deq     = (count != 2'd0) & out_ready;
  assign fetch   = enable & ~halt_q & ~redirect_valid & ((count != 2'd2) | deq);
  assign is_halt = (imem_instr == HALT_OPCODE);
  // Write slot is the occupancy left after this cycle's dequeue shift.
  assign fill    = count - {1'b0, deq};
  assign wr_idx  = fill[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= RESET_PC;
      count      <= 2'd0;
      halt_q     <= 1'b0;
      q_pc[0]    <= '0;
      q_pc[1]    <= '0;
      q_instr[0] <= '0;
      q_instr[1] <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      count  <= 2'd0;
      halt_q <= 1'b0;
    end else begin
      if (deq) begin
        q_pc[0]    <= q_pc[1];
        q_instr[0] <= q_instr[1];
      end
      if (fetch) begin
        q_pc[wr_idx]    <= pc;
        q_instr[wr_idx] <= imem_instr;
        if (is_halt) begin
          halt_q <= 1'b1;
        end else begin
          pc <= pc + ADDR_WIDTH'(1);
        end
      end
      count <= count + {1'b0, fetch} - {1'b0, deq};
    end
  end

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = q_instr[0];
  assign out_pc    = q_pc[0];
  assign halted    = halt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: stream, backpressure, redirect, halt, wrap,
// fetch disable and mid-operation reset against a small combinational imem.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [4:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [4:0]  out_pc;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        halted;

  logic [15:0] mem [32];
  int n_checks = 0;
  int n_fail   = 0;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  assign imem_instr = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] pc, input logic [15:0] instr);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, 32'(out_pc), 32'(pc));
    chk({tag, "_instr"}, 32'(out_instr), 32'(instr));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 5'd0;

    // reset state
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_instr", 32'(out_instr), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);

    // streaming, no bubbles
    reset = 1'b1;
    tick(); chk_out("s0", 5'd0, 16'h1111); chk("s0_addr", 32'(imem_addr), 32'd1);
    tick(); chk_out("s1", 5'd1, 16'h2222);
    tick(); chk_out("s2", 5'd2, 16'h3333); chk("s2_addr", 32'(imem_addr), 32'd3);

    // backpressure
    reset = 1'b0; tick();
    reset = 1'b1; out_ready = 1'b0;
    tick(); chk_out("bp0", 5'd0, 16'h1111); chk("bp0_cnt", 32'(dut.count), 32'd1);
    tick(); tick(); tick();
    chk_out("bp3", 5'd0, 16'h1111);
    chk("bp3_cnt", 32'(dut.count), 32'd2);
    chk("bp3_addr", 32'(imem_addr), 32'd2);
    out_ready = 1'b1;
    tick(); chk_out("bp_r1", 5'd1, 16'h2222); chk("bp_r1_addr", 32'(imem_addr), 32'd3);
    tick(); chk_out("bp_r2", 5'd2, 16'h3333);
    tick(); chk_out("bp_r3", 5'd3, 16'hA003);

    // redirect while queue holds pcs 1 and 2
    reset = 1'b0; tick();
    reset = 1'b1; out_ready = 1'b0;
    tick(); tick();
    out_ready = 1'b1;
    tick(); chk_out("rd_pre", 5'd1, 16'h2222); chk("rd_pre_cnt", 32'(dut.count), 32'd2);
    redirect_valid = 1'b1; redirect_pc = 5'd5;
    tick(); chk("rd_valid0", 32'(out_valid), 32'd0); chk("rd_addr", 32'(imem_addr), 32'd5);
    redirect_valid = 1'b0;
    tick(); chk_out("rd_tgt", 5'd5, 16'hA005);

    // halt at address 3
    mem[3] = 16'hFFFF;
    reset = 1'b0; tick();
    reset = 1'b1;
    tick(); chk_out("h0", 5'd0, 16'h1111);
    tick(); chk_out("h1", 5'd1, 16'h2222);
    tick(); chk_out("h2", 5'd2, 16'h3333); chk("h2_halted", 32'(halted), 32'd0);
    tick(); chk_out("h3", 5'd3, 16'hFFFF);
    chk("h3_halted", 32'(halted), 32'd1); chk("h3_addr", 32'(imem_addr), 32'd3);
    tick(); chk("h_drain", 32'(out_valid), 32'd0); chk("h_addr", 32'(imem_addr), 32'd3);
    tick(); chk("h_hold", 32'(out_valid), 32'd0); chk("h_hold_halted", 32'(halted), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 5'd0;
    tick(); chk("hr_halted", 32'(halted), 32'd0); chk("hr_addr", 32'(imem_addr), 32'd0);
    redirect_valid = 1'b0;
    tick(); chk_out("hr0", 5'd0, 16'h1111); chk("hr0_addr", 32'(imem_addr), 32'd1);

    // wrap around from 31
    redirect_valid = 1'b1; redirect_pc = 5'd31;
    tick(); chk("w_valid0", 32'(out_valid), 32'd0); chk("w_addr", 32'(imem_addr), 32'd31);
    redirect_valid = 1'b0;
    tick(); chk_out("w31", 5'd31, 16'hA01F); chk("w31_addr", 32'(imem_addr), 32'd0);
    tick(); chk_out("w0", 5'd0, 16'h1111);
    tick(); chk_out("w1", 5'd1, 16'h2222);

    // mid-operation reset with a full queue
    out_ready = 1'b0;
    tick(); tick();
    chk("mr_cnt", 32'(dut.count), 32'd2); chk("mr_halted", 32'(halted), 32'd0);
    reset = 1'b0;
    tick(); chk("mr_valid", 32'(out_valid), 32'd0); chk("mr_addr", 32'(imem_addr), 32'd0);
    reset = 1'b1; out_ready = 1'b1;
    tick(); chk_out("mr0", 5'd0, 16'h1111);

    // fetch disable: queue drains, pc freezes
    enable = 1'b0;
    tick(); chk("en_valid", 32'(out_valid), 32'd0); chk("en_addr", 32'(imem_addr), 32'd1);
    tick(); chk("en_addr2", 32'(imem_addr), 32'd1);
    enable = 1'b1;
    tick(); chk_out("en1", 5'd1, 16'h2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer that drives the combinational instruction memory (`imem`, 5-bit word address, 16-bit instruction). It owns the program counter and fetches one word per cycle into a 2-entry fetch queue. It presents instructions to decode over a valid/ready handshake. It handles branch redirects (queue flush) and stops fetching after a halt opcode.

## Interface
- `ADDR_WIDTH`, default 5: imem word-address width; PC width.
- `INSTR_WIDTH`, default 16: instruction width.
- `RESET_PC`, default 0: PC value after reset.
- `HALT_OPCODE`, default 16'hFFFF: instruction word that stops fetch.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  fetch enable; 0 freezes the PC and fetches nothing (queue still drains).
- `imem_addr`  out  ADDR_WIDTH  address to imem; equals the PC register.
- `imem_instr`  in  INSTR_WIDTH  imem read data, valid the same cycle as `imem_addr`.
- `out_valid`  out  1  queue head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  INSTR_WIDTH  head instruction.
- `out_pc`  out  ADDR_WIDTH  address the head instruction was fetched from.
- `redirect_valid`  in  1  branch/jump taken; flush and restart fetch.
- `redirect_pc`  in  ADDR_WIDTH  new fetch address.
- `halted`  out  1  halt opcode fetched; fetch stopped.

## Operation
- State: `pc`, 2-entry FIFO of {pc, instr}, 2-bit `count` (0..2), `halted` flag.
- Fetch condition: `fetch = enable & ~halted & ~redirect_valid & (count<2 | deq)`, where `deq = out_valid & out_ready`.
- On fetch: enqueue {pc, imem_instr}; pc <= pc+1 modulo 2^ADDR_WIDTH (31 wraps to 0).
- Dequeue on `deq`; the head advances. Simultaneous fetch and dequeue leaves `count` unchanged. This includes the full case, so full plus ready sustains 1 instruction per cycle.
- Halt: when `fetch` and `imem_instr == HALT_OPCODE`:
  - the halt word is enqueued and delivered normally;
  - `halted` <= 1 and pc holds at the halt word's address (no increment).
- While `halted`, no fetches. The queue still drains.
- Redirect (highest priority): `redirect_valid` empties the queue (`count` <= 0) and sets pc <= `redirect_pc`.
  - `halted` is cleared.
  - No enqueue that cycle. A same-cycle `out_ready` is a don't-care; the head is discarded.
- `enable`=0: pc and queue contents hold except for dequeue. Redirect is still honoured.
- Outputs are driven from registers only. `out_instr`/`out_pc` show entry 0 (head); when `count`=0 they are don't-care, but the bench checks them only when `out_valid`=1.

## Timing
- Reset (`reset`=0 at a rising edge): pc=RESET_PC, `imem_addr`=RESET_PC, `count`=0, `out_valid`=0, `out_instr`=0, `out_pc`=0, `halted`=0. Reset overrides all other inputs, including mid-operation; in-flight entries are lost.
- Latency: the word at address A is on `out_instr` with `out_valid`=1 in the cycle after the edge at which pc=A was fetched. First instruction after reset release: 1 cycle.
- Redirect latency: `out_valid`=0 the cycle after the redirect edge. The `redirect_pc` instruction is valid one cycle later, i.e. 2 cycles after the redirect is asserted.
- Backpressure: with `out_ready`=0 the queue fills in 2 cycles, then pc stalls. The head holds stable until accepted.
- The handshake follows standard valid/ready rules: `out_valid` is never deasserted without a dequeue, except by redirect or reset.

## Test plan
- Reset/stream: imem preloaded 0:1111, 1:2222, 2:3333; reset low 2 cycles, `enable`=1, `out_ready`=1.
  - Expect: 1 cycle after release out={pc 0, 1111}, then {1,2222}, then {2,3333} on consecutive cycles, no bubbles.
- Backpressure: `out_ready`=0 for 4 cycles after the first valid.
  - Expect: `out_pc`=0 holds, `count`=2, `imem_addr` stalls at 2.
  - After release: pcs 0, 1, 2 are delivered in order with no loss or duplication.
- Redirect: assert `redirect_valid` with `redirect_pc`=5 while the queue holds pcs 1 and 2.
  - Expect: next cycle `out_valid`=0; following cycle out={pc 5, mem[5]}; pcs 1/2 never accepted.
- Halt: mem[3]=FFFF.
  - Expect: pcs 0..3 delivered, the last with instr FFFF; `halted`=1, `imem_addr` holds 3, `out_valid` drops after drain.
  - Then redirect to 0: `halted`=0 and fetch resumes at 0.
- Wrap: redirect to 31.
  - Expect: out pcs 31, 0, 1 consecutively.
- Mid-operation reset: assert reset while the queue is full and `halted`=0.
  - Expect: next cycle `out_valid`=0, `imem_addr`=RESET_PC, and the first instruction after release is mem[0].
